// File: rtl/i2c_lockstep_writer.sv
// i2c_lockstep_writer: N-channel lockstep I2C register-write master with device reset sequencing
module i2c_lockstep_writer #(
  parameter int CHANNELS        = 4,
  parameter int CLK_DIV         = 125,
  parameter int RESETN_CYCLES   = 1000,
  parameter int STRETCH_TIMEOUT = 65535
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CHANNELS-1:0] cmd_mask,
  input  logic [6:0]          cmd_addr,
  input  logic [7:0]          cmd_reg,
  input  logic [7:0]          cmd_data,
  output logic                done_valid,
  output logic [CHANNELS-1:0] done_nack,
  output logic                done_timeout,
  output logic [CHANNELS-1:0] sda_out,
  input  logic [CHANNELS-1:0] sda_in,
  output logic [CHANNELS-1:0] scl_out,
  input  logic [CHANNELS-1:0] scl_in,
  output logic [CHANNELS-1:0] resetn
);
  localparam int QW = $clog2(CLK_DIV);
  localparam int RW = $clog2(RESETN_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_TIMEOUT + 1);
  localparam logic [QW-1:0] Q_MAX = QW'(CLK_DIV - 1);
  localparam logic [RW-1:0] R_MAX = RW'(RESETN_CYCLES - 1);
  localparam logic [SW-1:0] S_MAX = SW'(STRETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {RST_HOLD, IDLE, START, BITS, STOP, DONE} state_t;

  state_t              state, nxt;
  logic [QW-1:0]       qc;
  logic [1:0]          ph;
  logic [4:0]          bi;
  logic [SW-1:0]       sc;
  logic [RW-1:0]       rc;
  logic [CHANNELS-1:0] mask;
  logic [26:0]         stream;
  logic                active, accept, stalled, wrap, last_ph, tmo_hit, ack_slot, sda, scl;

  // Shared bit-engine decode: stretch freeze, phase wrap, timeout and line levels
  always_comb begin
    active   = state inside {START, BITS, STOP};
    accept   = state == IDLE && cmd_valid;
    stalled  = ((state == BITS && ph == 2'd2) || (state == STOP && ph == 2'd1)) && |(mask & ~scl_in);
    wrap     = active && !stalled && qc == Q_MAX;
    last_ph  = wrap && ph == 2'd3;
    tmo_hit  = stalled && sc == S_MAX;
    ack_slot = bi == 5'd8 || bi == 5'd17 || bi == 5'd26;
    sda      = state == START ? ph == 2'd0 : state == BITS ? stream[26] : state == STOP ? ph[1] : 1'b1;
    scl      = state == START ? ph != 2'd3 : state == BITS ? ph[1] : state == STOP ? ph != 2'd0 : 1'b1;
  end

  // Next-state selection; a stretch timeout short-circuits straight to DONE
  always_comb begin
    nxt = state;
    case (state)
      RST_HOLD: nxt = rc == R_MAX ? IDLE : RST_HOLD;
      IDLE:     nxt = accept ? (|cmd_mask ? START : DONE) : IDLE;
      START:    nxt = last_ph ? BITS : START;
      BITS:     nxt = tmo_hit ? DONE : (last_ph && bi == 5'd26) ? STOP : BITS;
      STOP:     nxt = tmo_hit || last_ph ? DONE : STOP;
      DONE:     nxt = IDLE;
      default:  nxt = RST_HOLD;
    endcase
  end

  // State, counters, latched command and sticky result flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RST_HOLD;
      rc           <= '0;
      qc           <= '0;
      ph           <= '0;
      bi           <= '0;
      sc           <= '0;
      mask         <= '0;
      stream       <= '0;
      done_nack    <= '0;
      done_timeout <= 1'b0;
    end else begin
      state <= nxt;
      rc    <= state == RST_HOLD ? rc + 1'b1 : '0;
      qc    <= !active || wrap ? '0 : stalled ? qc : qc + 1'b1;
      sc    <= !active || wrap ? '0 : stalled ? sc + 1'b1 : sc;
      ph    <= !active ? 2'd0 : wrap ? ph + 2'd1 : ph;
      bi    <= state != BITS ? 5'd0 : last_ph ? bi + 5'd1 : bi;
      if (accept) begin
        mask         <= cmd_mask;
        stream       <= {cmd_addr, 1'b0, 1'b1, cmd_reg, 1'b1, cmd_data, 1'b1};
        done_nack    <= '0;
        done_timeout <= 1'b0;
      end else if (state == BITS && last_ph)
        stream <= {stream[25:0], 1'b1};
      if (tmo_hit) begin
        done_timeout <= 1'b1;
        done_nack    <= mask;
      end else if (state == BITS && ph == 2'd2 && wrap && ack_slot)
        done_nack <= done_nack | (mask & sda_in);
    end
  end

  assign cmd_ready  = state == IDLE;
  assign done_valid = state == DONE;
  assign sda_out    = ~mask | {CHANNELS{sda}};
  assign scl_out    = ~mask | {CHANNELS{scl}};
  assign resetn     = {CHANNELS{state != RST_HOLD}};
endmodule

// File: tb/tb_i2c_lockstep_writer.sv
// tb_i2c_lockstep_writer: directed self-checking bench for the lockstep I2C writer
module tb_i2c_lockstep_writer;
  logic       clock = 1'b0, reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, done_valid, done_timeout;
  logic [3:0] cmd_mask = '0, done_nack, sda_out, sda_in, scl_out, scl_in, resetn;
  logic [6:0] cmd_addr = 7'h3C;
  logic [7:0] cmd_reg = 8'h12, cmd_data = 8'hA5;
  logic [3:0] pull = 4'hF, hold = 4'h0;
  logic [27:0] cap, exp_stream;
  logic       prev_scl = 1'b1;
  int         compared = 0, mismatched = 0;
  int         rises = 0, lock_bad = 0, rel_bad = 0, any_low = 0;
  int         lat;

  i2c_lockstep_writer #(
    .CHANNELS(4), .CLK_DIV(4), .RESETN_CYCLES(16), .STRETCH_TIMEOUT(50)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mask(cmd_mask), .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .done_valid(done_valid), .done_nack(done_nack), .done_timeout(done_timeout),
    .sda_out(sda_out), .sda_in(sda_in), .scl_out(scl_out), .scl_in(scl_in), .resetn(resetn)
  );

  always #5 clock = ~clock;

  assign sda_in = sda_out & ~pull;
  assign scl_in = scl_out & ~hold;

  // Bus monitor: captures SDA at each channel-0 SCL rise and tracks lockstep/release violations
  always @(negedge clock) begin
    if (!prev_scl && scl_out[0]) begin
      cap = {cap[26:0], sda_out[0]};
      rises++;
    end
    prev_scl = scl_out[0];
    if (sda_out[0] !== sda_out[2] || scl_out[0] !== scl_out[2]) lock_bad++;
    if ({sda_out[3], sda_out[1], scl_out[3], scl_out[1]} !== 4'hF) rel_bad++;
    if ({sda_out, scl_out} !== 8'hFF) any_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_seq();
    int bad = 0;
    @(negedge clock);
    reset = 1'b1;
    repeat (15) begin
      @(negedge clock);
      if (resetn !== 4'h0 || cmd_ready !== 1'b0) bad++;
    end
    chk("rst_hold", bad, 0);
    @(negedge clock);
    chk("resetn_rel", resetn, 4'hF);
    chk("ready_rel", cmd_ready, 1);
  endtask

  task automatic do_cmd(input logic [3:0] m, input int st_at, input int st_len, output int l);
    @(negedge clock);
    cap = '0; rises = 0; lock_bad = 0; rel_bad = 0; any_low = 0;
    cmd_mask  = m;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    l = 0;
    do begin
      @(negedge clock);
      l++;
      if (st_len > 0 && l == st_at) hold[0] = 1'b1;
      if (st_len > 0 && l == st_at + st_len) hold[0] = 1'b0;
    end while (!done_valid && l < 3000);
    chk("done_seen", done_valid, 1);
  endtask

  task automatic post(input string tag);
    @(negedge clock);
    chk({tag, "_pulse1"}, done_valid, 0);
    chk({tag, "_idle"}, cmd_ready, 1);
  endtask

  initial begin
    exp_stream = {8'h78, 1'b1, 8'h12, 1'b1, 8'hA5, 1'b1, 1'b0};
    #1;
    chk("rst_sda", sda_out, 4'hF);
    chk("rst_scl", scl_out, 4'hF);
    chk("rst_resetn", resetn, 4'h0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", {done_valid, done_timeout, done_nack}, 0);
    repeat (3) @(negedge clock);
    reset_seq();

    pull = 4'hF;
    do_cmd(4'b0101, 0, 0, lat);
    chk("ack_lat", lat, 465);
    chk("ack_nack", done_nack, 4'h0);
    chk("ack_tmo", done_timeout, 0);
    chk("ack_stream", cap, exp_stream);
    chk("ack_rises", rises, 28);
    chk("ack_lockstep", lock_bad, 0);
    chk("ack_unmasked", rel_bad, 0);
    post("ack");

    pull = 4'b1011;
    do_cmd(4'b0101, 0, 0, lat);
    chk("nack_lat", lat, 465);
    chk("nack_nack", done_nack, 4'b0100);
    chk("nack_stream", cap, exp_stream);
    chk("nack_rises", rises, 28);
    post("nack");
    @(negedge clock);
    chk("nack_held", done_nack, 4'b0100);

    pull = 4'hF;
    do_cmd(4'b0101, 73, 20, lat);
    chk("str_lat", lat, 485);
    chk("str_nack", done_nack, 4'h0);
    chk("str_stream", cap, exp_stream);
    chk("str_lockstep", lock_bad, 0);
    chk("str_unmasked", rel_bad, 0);
    post("str");

    hold[0] = 1'b1;
    do_cmd(4'b0101, 0, 0, lat);
    chk("tmo_bound", lat < 200, 1);
    chk("tmo_flag", done_timeout, 1);
    chk("tmo_nack", done_nack, 4'b0101);
    chk("tmo_sda", sda_out, 4'hF);
    chk("tmo_scl", scl_out, 4'hF);
    post("tmo");
    hold[0] = 1'b0;

    do_cmd(4'b0000, 0, 0, lat);
    chk("m0_lat", lat, 1);
    chk("m0_nack", done_nack, 4'h0);
    chk("m0_tmo", done_timeout, 0);
    post("m0");
    chk("m0_quiet", any_low, 0);

    @(negedge clock);
    cmd_mask  = 4'b0101;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    repeat (40) @(negedge clock);
    chk("mid_busy", scl_out, 4'b1010);
    #2 reset = 1'b0;
    #1;
    chk("mid_sda", sda_out, 4'hF);
    chk("mid_scl", scl_out, 4'hF);
    chk("mid_resetn", resetn, 4'h0);
    chk("mid_ready", cmd_ready, 0);
    reset_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/i2c_lockstep_writer.md
Name: i2c_lockstep_writer

Overview:
- Parametrised N-channel I2C write master. It drives CHANNELS independent open-drain I2C buses in lockstep from one shared bit engine.
- Each command performs one register write, START + {addr,W} + reg + data + STOP, on every channel selected by a mask. It returns a per-channel NACK report.
- It also sequences the per-channel device reset lines after power-up.
- It sits between the refresh controller and the top-level tristate pads. Pad convention is out=1 means release (Z) and out=0 means drive low.

Parameters:
- CHANNELS, 4, number of I2C buses.
- CLK_DIV, 125, clock cycles per quarter-bit phase (minimum 2).
- RESETN_CYCLES, 1000, clock cycles resetn is held low after reset release.
- STRETCH_TIMEOUT, 65535, maximum clock cycles spent waiting for SCL high before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_mask  in  CHANNELS  channels to transact on
- cmd_addr  in  7  7-bit device address
- cmd_reg  in  8  register index
- cmd_data  in  8  register data
- done_valid  out  1  one-cycle completion pulse
- done_nack  out  CHANNELS  per-channel NACK seen (valid with done_valid, held until next accept)
- done_timeout  out  1  transaction aborted by SCL stretch timeout
- sda_out  out  CHANNELS  per-channel SDA drive (1 = release)
- sda_in  in  CHANNELS  per-channel SDA pad
- scl_out  out  CHANNELS  per-channel SCL drive (1 = release)
- scl_in  in  CHANNELS  per-channel SCL pad
- resetn  out  CHANNELS  per-channel device reset, active low

Behaviour:
- Reset (reset=0) values:
  - sda_out and scl_out all 1.
  - resetn all 0, cmd_ready 0.
  - done_valid, done_nack and done_timeout all 0.
  - State RST_HOLD.
- RST_HOLD: count RESETN_CYCLES clocks after reset release, then set resetn all 1 and enter IDLE.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready.
  - On accept, latch mask/addr/reg/data and clear done_nack/done_timeout.
  - If mask==0: skip the bus, done_valid the next cycle, nack=0.
  - Otherwise go to START.
- Phase timing: a quarter counter runs 0..CLK_DIV-1. The phase advances when the counter wraps. The counter resets to 0 on every phase entry.
- Unmasked channels: sda_out=1 and scl_out=1 at all times. Only masked channels are driven.
- START, 4 quarters (SDA, SCL): q0 (1,1); q1 (0,1); q2 (0,1); q3 (0,0).
- BITS: 27 bits, MSB first, from bytes {addr,1'b0}, reg, data. Bits 8/17/26 of the 27-bit stream are ACK slots, with SDA released.
  - q0: SCL=0, SDA=bit.
  - q1: SCL=0, SDA held.
  - q2: SCL released. The quarter counter is frozen while any masked scl_in==0 (clock stretch, AND across the mask).
  - q3: SCL=1.
  - Sampling: at the q2→q3 transition, in ACK slots, every masked channel with sda_in==1 sets its sticky done_nack bit.
  - A NACK does not abort. All 27 bits complete on all masked channels.
- STOP, 4 quarters (SDA, SCL): q0 (0,0); q1 (0,1), stretch-waited like q2 of BITS; q2 (1,1); q3 (1,1). Then DONE.
- DONE: done_valid=1 for exactly one cycle, then IDLE.
- Stretch timeout:
  - A separate counter counts cycles frozen in a stretch quarter and resets on each phase entry.
  - Reaching STRETCH_TIMEOUT: release all lines immediately, set done_timeout=1 and done_nack=cmd_mask, pulse done_valid, return to IDLE.
- Unstretched latency: accept → done_valid = 1 + (4+108+4)·CLK_DIV cycles.
- New cmd_valid during a transaction is ignored (cmd_ready=0). No queueing.
- Reset asserted mid-transaction: all lines release immediately, resetn drops to 0, and RST_HOLD restarts.

Test Plan:
- Bench config: CHANNELS=4, CLK_DIV=4, RESETN_CYCLES=16.
- Power-up: release reset → resetn=0000 and cmd_ready=0 for 16 cycles, then resetn=1111 and cmd_ready=1.
- Write mask=0101, addr=0x3C, reg=0x12, data=0xA5, all ACK pulled low → channels 0 and 2 carry identical waveforms: byte 0x78, byte 0x12, byte 0xA5. Channels 1 and 3 stay released. done_valid at exactly 465 cycles after accept, nack=0000.
- Same write, channel 2 leaves SDA high in all ACK slots → done_nack=0100, still all 27 bits plus STOP, same latency.
- Channel 0 holds scl_in low for 20 cycles in bit 3 q2 → channel 2 SCL also waits (lockstep), latency grows by 20 cycles, data correct.
- STRETCH_TIMEOUT=50, channel 0 holds SCL low forever → done_timeout=1, done_nack=0101, all sda_out/scl_out=1, back in IDLE.
- mask=0000 → done_valid one cycle after accept, no pad toggles. Separately, assert reset mid-byte → lines release at once and the resetn sequence repeats.
